mem_stage: RTL and testbench

- MEM stage of the 5-stage in-order pipeline; sits between EX and WB.
- It is the producing end of the MEM→WB valid/allowin handshake and the source of the `{we, waddr, wdata}` register-file bus that WB consumes.
- Accepts EX results, captures the synchronous data-SRAM read data, and performs load byte/halfword extraction with sign or zero extension.
- Also drives a same-cycle forwarding bus to ID.

---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/mem_load_align.sv | 31 +++
 rtl/mem_stage.sv | 90 +++++++++
 tb/tb_mem_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: load-op encodings and the 38-bit RF bus layout.
package mem_stage_pkg;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  localparam int RF_BUS_W     = 38;
  localparam int RF_WE_BIT    = 37;
  localparam int RF_WADDR_LSB = 32;
  localparam int RF_WDATA_LSB = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_bus_t;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load extraction: picks byte/halfword/word by address offset and extends.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  ld_op,
  output logic [31:0] load_result
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign shifted = rdata >> {off, 3'b000};
  assign byte_v  = shifted[7:0];
  // Halfword ignores off[0]; misaligned accesses are trapped before MEM.
  assign half_v  = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_result = rdata;
    case (ld_op)
      LD_B:    load_result = {{24{byte_v[7]}}, byte_v};
      LD_BU:   load_result = {24'h0, byte_v};
      LD_H:    load_result = {{16{half_v[15]}}, half_v};
      LD_HU:   load_result = {16'h0, half_v};
      default: load_result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers EX results, holds SRAM load data across WB stalls,
// and produces the WB register-file bus plus the ID forwarding bus.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  output logic                MEM_allowin,
  input  logic                EX_MEM_valid,
  input  logic [31:0]         EX_pc,
  input  logic                EX_rf_we,
  input  logic [4:0]          EX_rf_waddr,
  input  logic [31:0]         EX_alu_result,
  input  logic                EX_res_from_mem,
  input  logic [2:0]          EX_ld_op,
  input  logic [31:0]         data_sram_rdata,
  input  logic                WB_allowin,
  output logic                MEM_WB_valid,
  output logic [31:0]         MEM_pc,
  output logic [RF_BUS_W-1:0] MEM_rf_bus,
  output logic [RF_BUS_W-1:0] MEM_fwd_bus
);

  logic        valid_q, first_q;
  logic [31:0] pc_q, alu_q, rbuf_q;
  logic        we_q, res_mem_q;
  logic [4:0]  waddr_q;
  logic [2:0]  ld_op_q;

  logic        ready_go, accept;
  logic [31:0] rdata, load_result, wdata;
  rf_bus_t     rf_bus, fwd_bus;

  assign ready_go     = 1'b1;
  assign MEM_allowin  = ~valid_q | (ready_go & WB_allowin);
  assign MEM_WB_valid = valid_q & ready_go;
  assign accept       = EX_MEM_valid & MEM_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      pc_q      <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      alu_q     <= '0;
      res_mem_q <= 1'b0;
      ld_op_q   <= '0;
      rbuf_q    <= '0;
    end else begin
      if (MEM_allowin) valid_q <= EX_MEM_valid;
      first_q <= accept;
      // SRAM data is only valid in the first cycle; keep a copy for stalls.
      if (first_q) rbuf_q <= data_sram_rdata;
      if (accept) begin
        pc_q      <= EX_pc;
        we_q      <= EX_rf_we;
        waddr_q   <= EX_rf_waddr;
        alu_q     <= EX_alu_result;
        res_mem_q <= EX_res_from_mem;
        ld_op_q   <= EX_ld_op;
      end
    end
  end

  assign rdata = first_q ? data_sram_rdata : rbuf_q;

  mem_load_align u_align (
    .rdata       (rdata),
    .off         (alu_q[1:0]),
    .ld_op       (ld_op_q),
    .load_result (load_result)
  );

  assign wdata = res_mem_q ? load_result : alu_q;

  always_comb begin
    rf_bus       = '0;
    rf_bus.we    = we_q;
    rf_bus.waddr = waddr_q;
    rf_bus.wdata = wdata;
    fwd_bus      = rf_bus;
    fwd_bus.we   = valid_q & we_q;
  end

  assign MEM_pc      = pc_q;
  assign MEM_rf_bus  = rf_bus;
  assign MEM_fwd_bus = fwd_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load-extraction vector table plus handshake/stall/reset sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        MEM_allowin;
  logic        EX_MEM_valid;
  logic [31:0] EX_pc;
  logic        EX_rf_we;
  logic [4:0]  EX_rf_waddr;
  logic [31:0] EX_alu_result;
  logic        EX_res_from_mem;
  logic [2:0]  EX_ld_op;
  logic [31:0] data_sram_rdata;
  logic        WB_allowin;
  logic        MEM_WB_valid;
  logic [31:0] MEM_pc;
  logic [37:0] MEM_rf_bus;
  logic [37:0] MEM_fwd_bus;

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .MEM_allowin     (MEM_allowin),
    .EX_MEM_valid    (EX_MEM_valid),
    .EX_pc           (EX_pc),
    .EX_rf_we        (EX_rf_we),
    .EX_rf_waddr     (EX_rf_waddr),
    .EX_alu_result   (EX_alu_result),
    .EX_res_from_mem (EX_res_from_mem),
    .EX_ld_op        (EX_ld_op),
    .data_sram_rdata (data_sram_rdata),
    .WB_allowin      (WB_allowin),
    .MEM_WB_valid    (MEM_WB_valid),
    .MEM_pc          (MEM_pc),
    .MEM_rf_bus      (MEM_rf_bus),
    .MEM_fwd_bus     (MEM_fwd_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic we,
                          input logic [4:0] wa, input logic [31:0] alu,
                          input logic rm, input logic [2:0] op);
    EX_MEM_valid    = v;
    EX_pc           = pc;
    EX_rf_we        = we;
    EX_rf_waddr     = wa;
    EX_alu_result   = alu;
    EX_res_from_mem = rm;
    EX_ld_op        = op;
  endtask

  initial begin
    vecs[0]  = '{LD_B,   2'd3, 32'h80FF7F01, 32'hFFFFFF80};
    vecs[1]  = '{LD_BU,  2'd3, 32'h80FF7F01, 32'h00000080};
    vecs[2]  = '{LD_B,   2'd0, 32'h80FF7F01, 32'h00000001};
    vecs[3]  = '{LD_B,   2'd1, 32'h80FF7F01, 32'h0000007F};
    vecs[4]  = '{LD_B,   2'd2, 32'h80FF7F01, 32'hFFFFFFFF};
    vecs[5]  = '{LD_BU,  2'd2, 32'h80FF7F01, 32'h000000FF};
    vecs[6]  = '{LD_H,   2'd2, 32'h8001F00F, 32'hFFFF8001};
    vecs[7]  = '{LD_HU,  2'd2, 32'h8001F00F, 32'h00008001};
    vecs[8]  = '{LD_H,   2'd0, 32'h8001F00F, 32'hFFFFF00F};
    vecs[9]  = '{LD_HU,  2'd0, 32'h8001F00F, 32'h0000F00F};
    vecs[10] = '{LD_H,   2'd3, 32'h8001F00F, 32'hFFFF8001};
    vecs[11] = '{LD_W,   2'd1, 32'h8001F00F, 32'h8001F00F};
    vecs[12] = '{3'b111, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[13] = '{3'b011, 2'd2, 32'h13579BDF, 32'h13579BDF};

    resetn = 1'b0;
    WB_allowin = 1'b1;
    data_sram_rdata = 32'h0;
    drive_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b0);
    #12;
    chk("reset_valid",   {63'h0, MEM_WB_valid}, 64'h0);
    chk("reset_allowin", {63'h0, MEM_allowin},  64'h1);
    chk("reset_pc",      {32'h0, MEM_pc},       64'h0);
    chk("reset_rfbus",   {26'h0, MEM_rf_bus},   64'h0);
    chk("reset_fwdbus",  {26'h0, MEM_fwd_bus},  64'h0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // ALU op
    drive_ex(1'b1, 32'h1c000000, 1'b1, 5'd5, 32'h12345678, 1'b0, LD_W);
    tick();
    drive_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b0);
    #1;
    chk("alu_valid",  {63'h0, MEM_WB_valid}, 64'h1);
    chk("alu_pc",     {32'h0, MEM_pc}, 64'h1c000000);
    chk("alu_rfbus",  {26'h0, MEM_rf_bus},  {26'h0, 1'b1, 5'd5, 32'h12345678});
    chk("alu_fwdbus", {26'h0, MEM_fwd_bus}, {26'h0, 1'b1, 5'd5, 32'h12345678});
    tick();
    chk("alu_drain", {63'h0, MEM_WB_valid}, 64'h0);

    // Load extraction table
    for (int i = 0; i < 14; i++) begin
      drive_ex(1'b1, 32'h1c000100 + 32'(i*4), 1'b1, 5'(i + 1),
               32'h00001000 | {30'h0, vecs[i].off}, 1'b1, vecs[i].op);
      tick();
      drive_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b0);
      data_sram_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("load_vec%0d", i), {26'h0, MEM_rf_bus},
          {26'h0, 1'b1, 5'(i + 1), vecs[i].exp});
      tick();
    end

    // WB stall with SRAM changing under a held load
    drive_ex(1'b1, 32'h1c000200, 1'b1, 5'd9, 32'h00002000, 1'b1, LD_W);
    tick();
    drive_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b0);
    data_sram_rdata = 32'hDEADBEEF;
    WB_allowin = 1'b0;
    #1;
    chk("stall_first_wdata", {32'h0, MEM_rf_bus[31:0]}, 64'hDEADBEEF);
    chk("stall_first_allowin", {63'h0, MEM_allowin}, 64'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      data_sram_rdata = 32'h0;
      #1;
      chk($sformatf("stall_wdata_c%0d", c), {32'h0, MEM_rf_bus[31:0]}, 64'hDEADBEEF);
      chk($sformatf("stall_allowin_c%0d", c), {63'h0, MEM_allowin}, 64'h0);
      chk($sformatf("stall_valid_c%0d", c), {63'h0, MEM_WB_valid}, 64'h1);
    end
    WB_allowin = 1'b1;
    #1;
    chk("stall_release_allowin", {63'h0, MEM_allowin}, 64'h1);
    chk("stall_release_wdata", {32'h0, MEM_rf_bus[31:0]}, 64'hDEADBEEF);
    tick();
    chk("stall_drained", {63'h0, MEM_WB_valid}, 64'h0);

    // Back-to-back then bubble
    for (int k = 0; k < 4; k++) begin
      drive_ex(1'b1, 32'h1c000300 + 32'(k*4), 1'b1, 5'(k + 10),
               32'hA0000000 + 32'(k), 1'b0, LD_W);
      tick();
      chk($sformatf("b2b_valid%0d", k), {63'h0, MEM_WB_valid}, 64'h1);
      chk($sformatf("b2b_bus%0d", k), {26'h0, MEM_rf_bus},
          {26'h0, 1'b1, 5'(k + 10), 32'hA0000000 + 32'(k)});
    end
    drive_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b0);
    tick();
    chk("bubble_valid", {63'h0, MEM_WB_valid}, 64'h0);
    chk("bubble_fwd_we", {63'h0, MEM_fwd_bus[37]}, 64'h0);
    chk("bubble_rf_we_raw", {63'h0, MEM_rf_bus[37]}, 64'h1);

    // Async reset during a stall
    drive_ex(1'b1, 32'h1c000400, 1'b1, 5'd7, 32'h55555555, 1'b0, LD_W);
    WB_allowin = 1'b0;
    tick();
    drive_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b0);
    tick();
    chk("prerst_valid", {63'h0, MEM_WB_valid}, 64'h1);
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_valid",   {63'h0, MEM_WB_valid}, 64'h0);
    chk("arst_allowin", {63'h0, MEM_allowin},  64'h1);
    chk("arst_rfbus",   {26'h0, MEM_rf_bus},   64'h0);
    chk("arst_fwdbus",  {26'h0, MEM_fwd_bus},  64'h0);
    chk("arst_pc",      {32'h0, MEM_pc},       64'h0);
    @(negedge clk);
    resetn = 1'b1;
    WB_allowin = 1'b1;
    tick();
    tick();
    chk("postrst_valid", {63'h0, MEM_WB_valid}, 64'h0);
    chk("postrst_rfbus", {26'h0, MEM_rf_bus},   64'h0);
    drive_ex(1'b1, 32'h1c000500, 1'b1, 5'd3, 32'h00000042, 1'b0, LD_W);
    tick();
    drive_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b0);
    chk("postrst_accept", {26'h0, MEM_rf_bus}, {26'h0, 1'b1, 5'd3, 32'h00000042});
    chk("postrst_pc", {32'h0, MEM_pc}, 64'h1c000500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
